ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.
- It is the transmit counterpart to the scancode receive path, and shares the same open-drain PS/2 clock and data lines.
- It performs the inhibit/request-to-send sequence, shifts the byte out on device-generated clock edges, and checks the device ACK.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum system clocks allowed between device falling edges before the transfer aborts (15 ms).

Ports:
- clock  in  1  system clock; all logic is on posedge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled on the accept cycle.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high in IDLE only; the byte is accepted when tx_valid && tx_ready.
- tx_done  out  1  one-cycle pulse: device ACKed.
- tx_error  out  1  one-cycle pulse: no ACK, or timeout.
- busy  out  1  high whenever not IDLE; used to gate the receiver enable.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release.
- ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE; tx_ready=1.
  - tx_done, tx_error, busy, ps2_clk_oe and ps2_data_oe are all 0.
  - Synchronizer flops reset to 1; bit counter and timer reset to 0.
- Input synchronization:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
  - Falling edge (fe) = previous synchronized clock 1, current 0.
- Accept: on tx_valid && tx_ready, latch tx_data, latch odd parity = ~^tx_data, and go to INHIBIT.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START (1 cycle): ps2_clk_oe=1, ps2_data_oe=1 (start bit 0). Then go to SHIFT.
- SHIFT:
  - On entry, ps2_clk_oe=0; ps2_data_oe stays 1. Bit counter n=0.
  - On each fe, the host presents the next bit and n increments.
  - fe 1..8 present data bits 0..7, LSB first; fe 9 presents parity.
  - Presented bit b drives ps2_data_oe = ~b.
  - fe 10 releases data (stop bit, ps2_data_oe=0) and the state goes to ACK.
- ACK: on the next fe (11th), sample synchronized data.
  - Sample 0: tx_done pulse.
  - Sample 1: tx_error pulse.
  - Either way, go to IDLE with tx_ready=1 the following cycle.
- Timeout:
  - In SHIFT and ACK, the timer increments every cycle and clears on every fe.
  - When the timer reaches TIMEOUT_CYCLES: both oe go 0, tx_error pulses, state goes to IDLE.
- tx_valid while busy is ignored; the latched byte is unchanged.
- Reset asserted mid-transfer immediately releases both lines. No done/error pulse is generated.
- tx_done and tx_error are never high in the same cycle.
- Width rules:
  - n is 4 bits and saturates; it never wraps.
  - The timer has width clog2(TIMEOUT_CYCLES+1); the INHIBIT counter is sized likewise.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On a NACK or timeout, the block re-enters INHIBIT once with the latched byte. busy stays high.
  - tx_error pulses only if the retry also fails; tx_done pulses on retry success.
  - A 1-bit retry flag clears on accept.
- Undefined: the first failure pulses tx_error immediately. No retry logic is present.

Test Plan:
Simulation uses INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=200. The device model clocks at a period of 40 system clocks.
- Send 8'hED, device ACKs:
  - ps2_clk_oe is high for exactly 8 cycles, then START.
  - The model samples 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB-first, parity 1, stop 1).
  - tx_done pulses once; tx_ready=1 the next cycle.
- Send 8'h00, model leaves data high at the 11th edge:
  - The model sees parity 1.
  - tx_error pulses once; tx_done stays 0; both oe are 0.
- Send 8'h32, model never clocks after START:
  - tx_error pulses 200 cycles after SHIFT entry; both oe are 0; the state is IDLE.
- Reset low after the 4th fe of an 8'hFF send:
  - ps2_clk_oe and ps2_data_oe go 0 in the same cycle, with no pulse.
  - After reset high: tx_ready=1, busy=0.
- Send 8'hF4, then pulse tx_valid with 8'h55 during SHIFT:
  - The model receives 8'hF4 only, and exactly one tx_done.
- PS2_TX_RETRY_EN defined; first attempt NACK, second ACK:
  - Two INHIBIT phases occur; tx_error stays 0; tx_done pulses once.
  - With two NACKs, a single tx_error pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift on device clock, ACK check.
// Define PS2_TX_RETRY_EN to retry the latched byte once after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK} state_t;

    state_t          state, state_d;
    logic [7:0]      data_q, data_d;
    logic            par_q, par_d;
    logic [3:0]      n, n_d;
    logic [TW-1:0]   timer, timer_d;
    logic            data_oe_q, data_oe_d;
    logic            fail;
    logic            clk_s1, clk_s2, clk_prev, data_s1, data_s2;
    logic            fe;
`ifdef PS2_TX_RETRY_EN
    logic            retry_q, retry_d;
`endif

    // Line synchronizers idle high so a released bus never looks like an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            n         <= '0;
            timer     <= '0;
            data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            n         <= n_d;
            timer     <= timer_d;
            data_oe_q <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        data_d    = data_q;
        par_d     = par_q;
        n_d       = n;
        timer_d   = timer;
        data_oe_d = data_oe_q;
        tx_done   = 1'b0;
        tx_error  = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state)
            IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    timer_d = '0;
                    state_d = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                    state_d   = START;
                    timer_d   = '0;
                    data_oe_d = 1'b1;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            START: begin
                state_d   = SHIFT;
                n_d       = '0;
                timer_d   = '0;
                data_oe_d = 1'b1;
            end
            SHIFT: begin
                if (fe) begin
                    timer_d = '0;
                    if (n != 4'hF) n_d = n + 4'd1;
                    // edges 1..8 carry data LSB first, edge 9 parity, edge 10 the released stop bit
                    if (n < 4'd8)       data_oe_d = ~data_q[n[2:0]];
                    else if (n == 4'd8) data_oe_d = ~par_q;
                    else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES)) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            ACK: begin
                if (fe) begin
                    timer_d = '0;
                    if (!data_s2) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES)) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            data_oe_d = 1'b0;
            timer_d   = '0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = INHIBIT;
            end else begin
                tx_error = 1'b1;
                state_d  = IDLE;
            end
`else
            tx_error = 1'b1;
            state_d  = IDLE;
`endif
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
    assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a clocking keyboard, frame scoreboard, per-cycle checker.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 8;
    localparam int TO  = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    int   total = 0, bad = 0;
    int   done_cnt = 0, err_cnt = 0, inh_cnt = 0, last_k = 0, k = 0;
    bit   in_txn = 1'b0;
    logic prev_clk_oe = 1'b0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected 11-bit frame as the device sees it, bit 0 first: start, data LSB-first, odd parity, stop.
    function automatic logic [10:0] frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Per-cycle checker; k counts cycles since the accept edge of the current transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
            chk("rst_ready", tx_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            chk("rst_pulse", {tx_done, tx_error}, 0);
        end else begin
            chk("pulse_excl", tx_done & tx_error, 0);
            if (in_txn) k++;
            if (!in_txn) begin
                chk("idle_ready", tx_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("idle_pulse", {tx_done, tx_error}, 0);
                if (tx_valid) begin
                    in_txn  = 1'b1;
                    k       = 0;
                    inh_cnt = 0;
                end
            end else begin
                chk("txn_busy", {busy, tx_ready}, 2'b10);
                if (k >= 1 && k <= INH)  chk("inhibit_oe", {ps2_clk_oe, ps2_data_oe}, 2'b10);
                else if (k == INH + 1)   chk("start_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
                else if (k == INH + 2)   chk("shift_entry_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
`ifndef PS2_TX_RETRY_EN
                else                     chk("shift_clk_oe", ps2_clk_oe, 0);
`endif
                if (k <= INH + 2) chk("early_pulse", {tx_done, tx_error}, 0);
                if (ps2_clk_oe && !prev_clk_oe) inh_cnt++;
                if (tx_done)  begin done_cnt++; last_k = k; in_txn = 1'b0; end
                if (tx_error) begin err_cnt++;  last_k = k; in_txn = 1'b0; end
            end
        end
        prev_clk_oe = ps2_clk_oe;
    end

    // Keyboard model. mode 0: ACK, 1: NACK, 2: never clocks. Clocks at a 40-cycle period.
    task automatic dev(input int mode, input int maxfe, output logic [10:0] bits);
        int t;
        bits = '1;
        t = 0;
        while (!(ps2_clk_in && !ps2_data_in) && t < 3000) begin @(posedge clk); #1; t++; end
        chk("rts_seen", ps2_clk_in && !ps2_data_in, 1);
        if (mode == 2) begin
            t = 0;
            while (busy && !ps2_clk_oe && t < 1000) begin @(posedge clk); #1; t++; end
            return;
        end
        for (int i = 0; i < 11 && i < maxfe; i++) begin
            repeat (20) @(posedge clk);
            #1;
            bits[i] = ps2_data_in;
            if (i == 10 && mode == 0) begin
                dev_data = 1'b0;
                @(posedge clk); #1;
            end
            dev_clk = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic run_txn(input logic [7:0] b, input int m1, input int m2, input bit noise,
                           input logic [10:0] lit, input bit use_lit);
        int att, d0, e0, t;
        bit ok;
        logic [10:0] r1, r2;
`ifdef PS2_TX_RETRY_EN
        att = (m1 == 0) ? 1 : 2;
        ok  = (m1 == 0) || (m2 == 0);
`else
        att = 1;
        ok  = (m1 == 0);
`endif
        r1 = '1;
        r2 = '1;
        t = 0;
        while (!tx_ready && t < 5000) begin @(posedge clk); #1; t++; end
        chk("ready_wait", tx_ready, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        fork
            begin
                dev(m1, 11, r1);
                if (att == 2) dev(m2, 11, r2);
            end
            begin
                if (noise) begin
                    repeat (80) @(posedge clk);
                    #1;
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                    @(posedge clk); #1;
                    tx_valid = 1'b0;
                end
            end
        join
        t = 0;
        while ((done_cnt + err_cnt) == (d0 + e0) && t < 3000) begin @(posedge clk); #1; t++; end
        chk("done_count", done_cnt - d0, ok ? 1 : 0);
        chk("err_count", err_cnt - e0, ok ? 0 : 1);
        chk("inhibit_phases", inh_cnt, att);
        if (m1 != 2) chk("frame_try1", r1, frame(b));
        if (att == 2 && m2 != 2) chk("frame_try2", r2, frame(b));
        if (use_lit) chk("frame_literal", r1, lit);
`ifndef PS2_TX_RETRY_EN
        if (m1 == 2) chk("timeout_cycle", last_k, INH + 2 + TO);
`endif
        @(posedge clk); #1;
        chk("post_ready", tx_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        logic [10:0] r;
        int d0, e0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_txn(8'hED, 0, 0, 1'b0, 11'h7DA, 1'b1);
        run_txn(8'h00, 1, 1, 1'b0, 11'h600, 1'b1);
        run_txn(8'h32, 2, 2, 1'b0, 11'h000, 1'b0);

        // Reset in the middle of an 8'hFF shift, after four device falling edges.
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk); #1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        dev(0, 4, r);
        chk("partial_bits", r[3:0], 4'hE);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("midrst_pulse", {tx_done, tx_error}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_ready", tx_ready, 1);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        run_txn(8'hF4, 0, 0, 1'b1, 11'h000, 1'b0);
`ifdef PS2_TX_RETRY_EN
        run_txn(8'hA5, 1, 0, 1'b0, 11'h000, 1'b0);
        run_txn(8'h3C, 1, 1, 1'b0, 11'h000, 1'b0);
`endif
        for (int i = 0; i < 12; i++)
            run_txn(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 11'h000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        bad++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
